// File: rtl/hazard_ctrl_seq.sv
// Pipeline hazard controller: operand forwarding, sequenced load-use stall,
// masked branch flush and saturating stall/flush event counters.
module hazard_ctrl_seq #(
  parameter int DATA_W         = 32,
  parameter int REG_AW         = 4,
  parameter int LOAD_STALL_CYC = 1,
  parameter int FLUSH_STAGES   = 5,
  parameter logic [FLUSH_STAGES-1:0] BRANCH_FLUSH_MASK = 5'b01110,
  parameter int LOAD_BUBBLE_IDX = 1,
  parameter int CNT_W          = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [REG_AW-1:0]       Ra,
  input  logic [REG_AW-1:0]       Rb,
  input  logic [REG_AW-1:0]       id_ra,
  input  logic [REG_AW-1:0]       id_rb,
  input  logic [REG_AW-1:0]       ex_rd,
  input  logic                    ex_we,
  input  logic                    ex_is_load,
  input  logic [REG_AW-1:0]       Rd_EXMEM,
  input  logic [REG_AW-1:0]       Rd_MEMWB,
  input  logic                    exmem_we,
  input  logic                    memwb_we,
  input  logic [DATA_W-1:0]       aluResult,
  input  logic [DATA_W-1:0]       Result,
  input  logic                    branchTakenFlag,
  input  logic                    cnt_clr,
  output logic [1:0]              Fa,
  output logic [1:0]              Fb,
  output logic [DATA_W-1:0]       Forward1,
  output logic [DATA_W-1:0]       Forward2,
  output logic                    stall,
  output logic [FLUSH_STAGES-1:0] flush,
  output logic [CNT_W-1:0]        stall_cnt,
  output logic [CNT_W-1:0]        flush_cnt,
  output logic [0:0]              dbgState
);

  localparam logic [0:0] RUN    = 1'b0;
  localparam logic [0:0] LSTALL = 1'b1;
  localparam logic [FLUSH_STAGES-1:0] BUBBLE_BIT = FLUSH_STAGES'(1) << LOAD_BUBBLE_IDX;

  logic [0:0]              state, stateNext;
  logic [3:0]              cnt, cntNext;
  logic                    loadUse;
  logic                    stallRaw;
  logic [FLUSH_STAGES-1:0] flushRaw;
  logic                    branchFlush;

  // EX/MEM is the younger producer, so it takes priority over MEM/WB.
  always_comb begin
    Fa = 2'b00;
    if (exmem_we && Rd_EXMEM == Ra)      Fa = 2'b01;
    else if (memwb_we && Rd_MEMWB == Ra) Fa = 2'b10;
    Fb = 2'b00;
    if (exmem_we && Rd_EXMEM == Rb)      Fb = 2'b01;
    else if (memwb_we && Rd_MEMWB == Rb) Fb = 2'b10;
  end

  always_comb begin
    Forward1 = '0;
    Forward2 = '0;
    case (Fa)
      2'b01:   Forward1 = aluResult;
      2'b10:   Forward1 = Result;
      default: Forward1 = '0;
    endcase
    case (Fb)
      2'b01:   Forward2 = aluResult;
      2'b10:   Forward2 = Result;
      default: Forward2 = '0;
    endcase
  end

  assign loadUse = ex_is_load && ex_we && (ex_rd == id_ra || ex_rd == id_rb);

  always_comb begin
    stateNext   = state;
    cntNext     = cnt;
    stallRaw    = 1'b0;
    flushRaw    = '0;
    branchFlush = 1'b0;
    case (state)
      RUN: begin
        if (branchTakenFlag) begin
          flushRaw    = BRANCH_FLUSH_MASK;
          branchFlush = 1'b1;
        end else if (loadUse) begin
          stallRaw = 1'b1;
          flushRaw = BUBBLE_BIT;
          if (LOAD_STALL_CYC > 1) begin
            stateNext = LSTALL;
            cntNext   = 4'(LOAD_STALL_CYC - 1);
          end
        end
      end
      LSTALL: begin
        // EX already holds the bubble; every hazard input is ignored here.
        stallRaw = 1'b1;
        cntNext  = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          stateNext = RUN;
          cntNext   = 4'd0;
        end
      end
      default: begin
        stateNext = RUN;
        cntNext   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  // Gating with rst makes stall/flush drop the instant reset asserts.
  assign stall    = stallRaw & rst;
  assign flush    = flushRaw & {FLUSH_STAGES{rst}};
  assign dbgState = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && stall_cnt != '1)       stall_cnt <= stall_cnt + CNT_W'(1);
      if (branchFlush && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/hazard_ctrl_seq.md
# hazard_ctrl_seq

Parametrised pipeline hazard controller for the 5-stage core, replacing the purely combinational hazard unit. Provides 2-source operand forwarding from EX/MEM and MEM/WB, a multi-cycle load-use stall sequenced by an FSM and down-counter, per-stage flush generation on taken branches through a configurable mask, and saturating stall/flush performance counters. Sits beside the pipeline registers, between decode/execute control and the pipeline-register enable/clear inputs.

## Interface
- DATA_W, 32, operand/result width
- REG_AW, 4, register index width
- LOAD_STALL_CYC, 1, stall cycles per load-use hazard (1..15)
- FLUSH_STAGES, 5, width of flush vector; bit i clears pipeline register i (0 = IF/ID)
- BRANCH_FLUSH_MASK, 5'b01110, flush bits raised on taken branch
- LOAD_BUBBLE_IDX, 1, flush bit raised on the first load-use stall cycle (ID/EX bubble)
- CNT_W, 16, performance counter width

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- Ra, Rb  in  REG_AW  source registers of instruction in ID/EX
- id_ra, id_rb  in  REG_AW  source registers of instruction in ID
- ex_rd  in  REG_AW  destination of instruction in EX; ex_we, ex_is_load in 1 each
- Rd_EXMEM, Rd_MEMWB  in  REG_AW  destinations; exmem_we, memwb_we in 1 each
- aluResult  in  DATA_W  EX/MEM result; Result  in  DATA_W  MEM/WB writeback value
- branchTakenFlag  in  1  taken branch resolved in EX
- cnt_clr  in  1  synchronous clear of perf counters
- Fa, Fb  out  2  forward select: 00 none, 01 EX/MEM, 10 MEM/WB
- Forward1, Forward2  out  DATA_W  forwarded operand (0 when select 00)
- stall  out  1  hold PC and IF/ID
- flush  out  FLUSH_STAGES  per-stage clear
- stall_cnt, flush_cnt  out  CNT_W  saturating counters

## Operation
- Forwarding (combinational): Fa=01 if exmem_we && Rd_EXMEM==Ra; else 10 if memwb_we && Rd_MEMWB==Ra; else 00. Same for Fb/Rb. EX/MEM has priority. Forward1/2 = aluResult, Result or 0 per select. No register hardwired to zero.
- load_use = ex_is_load && ex_we && (ex_rd==id_ra || ex_rd==id_rb).
- FSM states RUN, LSTALL; 4-bit down-counter cnt.
- RUN: if branchTakenFlag: flush=BRANCH_FLUSH_MASK, stall=0 (branch wins over load_use). Else if load_use: stall=1, flush bit LOAD_BUBBLE_IDX=1; if LOAD_STALL_CYC>1 go LSTALL, cnt<=LOAD_STALL_CYC-1. Else stall=0, flush=0.
- LSTALL: stall=1, flush=0, inputs ignored (EX holds bubble; branchTakenFlag ignored). cnt decrements; when cnt==1 return RUN at next edge.
- stall_cnt +1 each cycle stall=1; flush_cnt +1 each cycle branch flush is issued; both saturate at all-ones; cnt_clr zeros both (clear beats increment).

## Timing
- Reset (rst=0, async): state RUN, cnt 0, stall_cnt/flush_cnt 0, stall 0, flush 0 forced while rst low.
- Forward/flush/stall in RUN: zero latency, combinational from inputs.
- Load-use stall length exactly LOAD_STALL_CYC consecutive cycles; bubble flush only on first.
- Back-to-back load-use after LSTALL exit re-evaluated in RUN the cycle after exit.
- Reset mid-LSTALL: immediate return to RUN, stall drops asynchronously.
- Counters update on rising edge following the event cycle.

## Test plan
- No hazard: Ra=1, Rb=2, Rd_EXMEM=10, Rd_MEMWB=15, both we=1 -> Fa=00, Fb=00, stall=0, flush=0.
- Forward priority: Ra=1, Rd_EXMEM=1, Rd_MEMWB=1, aluResult=10, Result=2 -> Fa=01, Forward1=10; set exmem_we=0 -> Fa=10, Forward1=2.
- Load-use, LOAD_STALL_CYC=3: ex_is_load=1, ex_rd=2, id_rb=2 -> stall=1 for exactly 3 cycles, flush=5'b00010 first cycle only, then stall=0; stall_cnt=3.
- Branch during load-use: branchTakenFlag=1 with load_use=1 -> stall=0, flush=5'b01110, flush_cnt increments 1; branchTakenFlag=1 while in LSTALL -> flush=0.
- Reset mid-stall: rst=0 on 2nd LSTALL cycle -> stall=0 without clock edge, counters 0, next load-use restarts full 3-cycle stall.
- Saturation: CNT_W=4, hold load-use 20 cycles -> stall_cnt stops at 15; cnt_clr=1 -> 0 next edge.
